// File: rtl/alu_issue_stage.sv
// Issue stage in front of a combinational N-bit ALU. It reads operands from a 4-entry register file,
// gives the ALU a full cycle to settle, then writes the result back and updates the carry and compare flags.
module alu_issue_stage #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [9:0]   instr,
    input  logic         ld_en,
    input  logic [1:0]   ld_addr,
    input  logic [N-1:0] ld_data,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_opcode,
    output logic         alu_cin,
    input  logic [N-1:0] alu_result,
    input  logic         alu_cout,
    input  logic         alu_cflag,
    output logic         wb_valid,
    output logic [1:0]   wb_addr,
    output logic [N-1:0] wb_data,
    output logic         carry_flag,
    output logic         cmp_flag
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_CMP = 3'b101;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t       state;
    state_t       next_state;
    logic [N-1:0] rf [4];
    logic [1:0]   rd_q;
    logic         accept;
    logic         retire;
    logic         rf_write;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        retire      = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept     = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                retire     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // alu_opcode stays stable through ISSUE, so it doubles as the latched opcode.
    assign rf_write = retire && (alu_opcode != OP_CMP);

    // The write-back is placed after the external load so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
            rd_q       <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            alu_cin    <= 1'b0;
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            carry_flag <= 1'b0;
            cmp_flag   <= 1'b0;
        end else begin
            if (ld_en) rf[ld_addr] <= ld_data;
            if (accept) begin
                rd_q       <= instr[6:5];
                alu_a      <= rf[instr[4:3]];
                alu_b      <= rf[instr[2:1]];
                alu_opcode <= instr[9:7];
                alu_cin    <= instr[0] & carry_flag;
            end
            wb_valid <= retire;
            if (retire) begin
                wb_addr <= rd_q;
                wb_data <= alu_result;
                if (rf_write) rf[rd_q] <= alu_result;
                if (alu_opcode == OP_ADD || alu_opcode == OP_SUB) carry_flag <= alu_cout;
                if (alu_opcode == OP_CMP) cmp_flag <= alu_cflag;
            end
        end
    end

endmodule
